pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 142 ++++++++++++++
 tb/tb_pipe_adder.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: carry-chunked pipelined adder/subtractor with valid/ready
// flow control. Each stage adds one CHUNK-bit slice, passes its carry to the
// next stage, forwards the result slices already computed, and skews the
// operand slices that later stages still have to add.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;

  // Reject parameter sets that cannot be split into whole chunks.
  if (CHUNK < 1) begin : g_bad_chunk
    $error("pipe_adder: CHUNK must be at least 1");
  end else if ((WIDTH < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
    $error("pipe_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Subtraction is folded into the operands at acceptance: A + ~B + 1.
  // From here on the transaction carries only the effective B and carry,
  // so the mode travels with its data and mixed modes need no extra state.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : stg
    // Width of the operand slices still unconsumed when entering this stage.
    localparam int REM = WIDTH - gi * CHUNK;

    logic                      valid_in;
    logic [REM-1:0]            a_src;
    logic [REM-1:0]            b_src;
    logic                      carry_src;
    logic [CHUNK:0]            chunk;
    logic [(gi+1)*CHUNK-1:0]   res_next;
    logic [(gi+1)*CHUNK-1:0]   res_reg;
    logic                      carry_reg;
    logic                      v;
    logic                      rdy;
    logic                      take;

    if (gi == 0) begin : g_src
      assign valid_in  = in_valid;
      assign a_src     = a;
      assign b_src     = b_eff;
      assign carry_src = cin_eff;
      assign res_next  = chunk[CHUNK-1:0];
    end else begin : g_src
      assign valid_in  = stg[gi-1].v;
      assign a_src     = stg[gi-1].g_skew.a_reg;
      assign b_src     = stg[gi-1].g_skew.b_reg;
      assign carry_src = stg[gi-1].carry_reg;
      assign res_next  = {chunk[CHUNK-1:0], stg[gi-1].res_reg};
    end

    // A stage may load when empty or when its contents move on this edge;
    // the empty case is what lets bubbles collapse under a downstream stall.
    if (gi == STAGES - 1) begin : g_rdy
      assign rdy = ~v | out_ready;
    end else begin : g_rdy
      assign rdy = ~v | stg[gi+1].rdy;
    end

    assign take  = rdy & valid_in;
    assign chunk = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry_src};

    // Valid bit: follows the upstream valid whenever this stage can advance.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v <= 1'b0;
      end else if (rdy) begin
        v <= valid_in;
      end
    end

    // Result slices and carry: only loaded with a real transaction, so the
    // last stage holds steady while stalled or empty.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        res_reg   <= '0;
        carry_reg <= 1'b0;
      end else if (take) begin
        res_reg   <= res_next;
        carry_reg <= chunk[CHUNK];
      end
    end

    if (gi < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] a_reg;
      logic [REM-CHUNK-1:0] b_reg;

      // Skew registers: operand slices still waiting for later stages.
      always_ff @(posedge clk) begin
        if (take) begin
          a_reg <= a_src[REM-1:CHUNK];
          b_reg <= b_src[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_next;
      logic ovf_reg;

      // Carry into the MSB is a^b^sum at the MSB; overflow is that XOR the
      // carry out of the MSB.
      assign ovf_next = a_src[CHUNK-1] ^ b_src[CHUNK-1] ^ chunk[CHUNK-1] ^ chunk[CHUNK];

      // Overflow flag registered alongside the final result slice.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (take) begin
          ovf_reg <= ovf_next;
        end
      end
    end
  end

  assign in_ready  = stg[0].rdy;
  assign out_valid = stg[STAGES-1].v;
  assign sum       = stg[STAGES-1].res_reg;
  assign cout      = stg[STAGES-1].carry_reg;
  assign ovf       = stg[STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder. Three instances are built:
// 32/8 for directed, backpressure and reset scenarios, 16/4 and 8/8 for the
// randomized flow-control run.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, or32, cin32, sub32, co32, of32;
  logic [31:0] a32, b32, s32;
  logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
  logic [7:0]  a8, b8, s8;

  pipe_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .cout(co32), .ovf(of32));

  pipe_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(of16));

  pipe_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .ovf(of8));

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t q32[$];
  res_t q16[$];
  res_t q8[$];

  int n_vec = 0;
  int n_bad = 0;

  localparam int NRAND = 10000;

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic s);
    logic [63:0] mask, xx, yy, f;
    res_t r;
    mask   = (64'd1 << w) - 64'd1;
    xx     = {32'd0, x} & mask;
    yy     = s ? (~{32'd0, y}) & mask : {32'd0, y} & mask;
    f      = xx + yy + (s ? 64'd1 : {63'd0, c});
    r.sum  = f[31:0] & mask[31:0];
    r.cout = f[w];
    r.ovf  = (xx[w-1] == yy[w-1]) && (r.sum[w-1] != xx[w-1]);
    return r;
  endfunction

  function automatic res_t got32();
    res_t r;
    r.sum = s32; r.cout = co32; r.ovf = of32;
    return r;
  endfunction

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    iv32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h1; cin32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b expected 0/1", ov32, ir32);
    end
    n_vec++;
    if ({s32, co32, of32} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b expected zeros", s32, co32, of32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    iv32 = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (ov32) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL reset_no_transfer: out_valid cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7};
    logic [31:0] tb[4] = '{32'd1, 32'd1, 32'd7, 32'd5};
    logic        tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] es[4] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'd2};
    logic        ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    res_t e, r;
    int lat;
    or32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv32 = 1'b1; a32 = ta[i]; b32 = tb[i]; cin32 = tc[i]; sub32 = ts[i];
      #1;
      n_vec++;
      if (ir32 !== 1'b1) begin
        n_bad++;
        $display("FAIL directed_in_ready[%0d]: in_ready=%b expected 1", i, ir32);
      end
      e.sum = es[i]; e.cout = ec[i]; e.ovf = eo[i];
      q32.push_back(e);
      @(negedge clk);
      iv32 = 1'b0;
      lat = 1;
      #1;
      while (!ov32 && lat < 20) begin
        @(negedge clk);
        #1;
        lat++;
      end
      n_vec++;
      if (lat != 4) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: latency=%0d expected 4", i, lat);
      end
      if (ov32 && q32.size() > 0) begin
        e = q32.pop_front();
        r = got32();
        n_vec++;
        if (r !== e) begin
          n_bad++;
          $display("FAIL directed_result[%0d]: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   i, r.sum, r.cout, r.ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
    q32.delete();
  endtask

  task automatic test_back_to_back();
    res_t e, r;
    int sent = 0, emitted = 0;
    or32 = 1'b1;
    for (int c = 0; c < 30 && emitted < 8; c++) begin
      @(negedge clk);
      iv32 = (sent < 8);
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
      #1;
      if (iv32) begin
        n_vec++;
        if (ir32 !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_in_ready[c%0d]: in_ready=%b expected 1", c, ir32);
        end
      end
      if (iv32 && ir32) begin
        q32.push_back(model(32, a32, b32, cin32, sub32));
        sent++;
      end
      if (ov32 && or32) begin
        n_vec++;
        if (c != emitted + 4) begin
          n_bad++;
          $display("FAIL b2b_timing[%0d]: cycle=%0d expected %0d", emitted, c, emitted + 4);
        end
        if (q32.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra: unexpected result sum=%h expected none", s32);
        end else begin
          e = q32.pop_front();
          r = got32();
          n_vec++;
          if (r !== e) begin
            n_bad++;
            $display("FAIL b2b_result[%0d]: got %h/%b/%b expected %h/%b/%b",
                     emitted, r.sum, r.cout, r.ovf, e.sum, e.cout, e.ovf);
          end
        end
        emitted++;
      end
    end
    iv32 = 1'b0;
    n_vec++;
    if (emitted != 8) begin
      n_bad++;
      $display("FAIL b2b_count: emitted=%0d expected 8", emitted);
    end
    q32.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] oa[6], ob[6];
    logic        os[6], oc[6];
    logic [31:0] held = 32'd0;
    res_t e, r;
    int idx = 0, emitted = 0;
    for (int i = 0; i < 6; i++) begin
      oa[i] = $urandom; ob[i] = $urandom; oc[i] = 1'($urandom); os[i] = 1'($urandom);
    end
    for (int c = 0; c < 40 && emitted < 6; c++) begin
      @(negedge clk);
      or32 = (c >= 8);
      iv32 = (idx < 6);
      if (idx < 6) begin
        a32 = oa[idx]; b32 = ob[idx]; cin32 = oc[idx]; sub32 = os[idx];
      end
      #1;
      if (c == 4) held = s32;
      if (c == 7) begin
        n_vec++;
        if (idx != 4 || ir32 !== 1'b0 || ov32 !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_fill: accepted=%0d in_ready=%b out_valid=%b expected 4/0/1", idx, ir32, ov32);
        end
        n_vec++;
        if (s32 !== held) begin
          n_bad++;
          $display("FAIL bp_stable: sum=%h expected held %h", s32, held);
        end
      end
      if (c == 8) begin
        n_vec++;
        if (ir32 !== 1'b1 || ov32 !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/1", ir32, ov32);
        end
      end
      if (iv32 && ir32) begin
        q32.push_back(model(32, a32, b32, cin32, sub32));
        idx++;
      end
      if (ov32 && or32) begin
        if (emitted < 4) begin
          n_vec++;
          if (c != 8 + emitted) begin
            n_bad++;
            $display("FAIL bp_timing[%0d]: cycle=%0d expected %0d", emitted, c, 8 + emitted);
          end
        end
        n_vec++;
        if (q32.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra: unexpected result sum=%h expected none", s32);
        end else begin
          e = q32.pop_front();
          r = got32();
          if (r !== e) begin
            n_bad++;
            $display("FAIL bp_result[%0d]: got %h/%b/%b expected %h/%b/%b",
                     emitted, r.sum, r.cout, r.ovf, e.sum, e.cout, e.ovf);
          end
        end
        emitted++;
      end
    end
    iv32 = 1'b0;
    n_vec++;
    if (emitted != 6) begin
      n_bad++;
      $display("FAIL bp_count: emitted=%0d expected 6", emitted);
    end
    q32.delete();
  endtask

  task automatic test_mid_reset();
    res_t e, r;
    int seen = 0, lat;
    or32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv32 = 1'b1; a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
      #1;
      n_vec++;
      if (ir32 !== 1'b1) begin
        n_bad++;
        $display("FAIL midrst_accept[%0d]: in_ready=%b expected 1", i, ir32);
      end
    end
    @(negedge clk);
    iv32 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (ov32 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_flush: out_valid=%b expected 0", ov32);
    end
    repeat (8) begin
      @(negedge clk);
      #1;
      if (ov32) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL midrst_discard: out_valid cycles=%0d expected 0", seen);
    end
    @(negedge clk);
    iv32 = 1'b1; a32 = 32'h0001_0000; b32 = 32'h0000_FFFF; cin32 = 1'b1; sub32 = 1'b0;
    e.sum = 32'h0002_0000; e.cout = 1'b0; e.ovf = 1'b0;
    q32.push_back(e);
    @(negedge clk);
    iv32 = 1'b0;
    lat = 1;
    #1;
    while (!ov32 && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (lat != 4) begin
      n_bad++;
      $display("FAIL midrst_latency: latency=%0d expected 4", lat);
    end
    if (ov32 && q32.size() > 0) begin
      e = q32.pop_front();
      r = got32();
      n_vec++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL midrst_result: got %h/%b/%b expected %h/%b/%b",
                 r.sum, r.cout, r.ovf, e.sum, e.cout, e.ovf);
      end
    end
    q32.delete();
  endtask

  task automatic test_random();
    int sent16 = 0, sent8 = 0, got16 = 0, got8 = 0, cyc = 0;
    logic hold16 = 1'b0, hold8 = 1'b0;
    logic [15:0] held16 = '0;
    logic [7:0]  held8 = '0;
    res_t e, r;
    while ((got16 < NRAND || got8 < NRAND) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      iv16 = (sent16 < NRAND) && ($urandom_range(0, 9) < 7);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
      or16 = ($urandom_range(0, 9) < 7);
      iv8 = (sent8 < NRAND) && ($urandom_range(0, 9) < 6);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      or8 = ($urandom_range(0, 9) < 6);
      #1;
      if (hold16) begin
        n_vec++;
        if (ov16 !== 1'b1 || s16 !== held16) begin
          n_bad++;
          $display("FAIL rand16_stall_hold: out_valid=%b sum=%h expected 1/%h", ov16, s16, held16);
        end
      end
      if (hold8) begin
        n_vec++;
        if (ov8 !== 1'b1 || s8 !== held8) begin
          n_bad++;
          $display("FAIL rand8_stall_hold: out_valid=%b sum=%h expected 1/%h", ov8, s8, held8);
        end
      end
      if (iv16 && ir16) begin
        q16.push_back(model(16, {16'd0, a16}, {16'd0, b16}, cin16, sub16));
        sent16++;
      end
      if (iv8 && ir8) begin
        q8.push_back(model(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8));
        sent8++;
      end
      if (ov16 && or16) begin
        n_vec++;
        r.sum = {16'd0, s16}; r.cout = co16; r.ovf = of16;
        if (q16.size() == 0) begin
          n_bad++;
          $display("FAIL rand16_extra: result sum=%h expected none", s16);
        end else begin
          e = q16.pop_front();
          if (r !== e) begin
            n_bad++;
            $display("FAIL rand16_result[%0d]: got %h/%b/%b expected %h/%b/%b",
                     got16, r.sum, r.cout, r.ovf, e.sum, e.cout, e.ovf);
          end
        end
        got16++;
      end
      if (ov8 && or8) begin
        n_vec++;
        r.sum = {24'd0, s8}; r.cout = co8; r.ovf = of8;
        if (q8.size() == 0) begin
          n_bad++;
          $display("FAIL rand8_extra: result sum=%h expected none", s8);
        end else begin
          e = q8.pop_front();
          if (r !== e) begin
            n_bad++;
            $display("FAIL rand8_result[%0d]: got %h/%b/%b expected %h/%b/%b",
                     got8, r.sum, r.cout, r.ovf, e.sum, e.cout, e.ovf);
          end
        end
        got8++;
      end
      hold16 = ov16 && !or16;
      held16 = s16;
      hold8  = ov8 && !or8;
      held8  = s8;
    end
    iv16 = 1'b0;
    iv8  = 1'b0;
    n_vec++;
    if (got16 != NRAND || got8 != NRAND || q16.size() != 0 || q8.size() != 0) begin
      n_bad++;
      $display("FAIL rand_complete: got16=%0d got8=%0d pending=%0d/%0d expected %0d each, 0 pending",
               got16, got8, q16.size(), q8.size(), NRAND);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    iv8  = 1'b0; or8  = 1'b1; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
